// File: rtl/caf_pkg.sv
// Shared CAF definitions: datapath width defaults and the peak-select state encoding.
package caf_pkg;

    // CAF slice datapath defaults
    localparam int CAF_DATA_BITS           = 8;
    localparam int CAF_OUT_MAX_BITS        = 5;
    localparam int CAF_LENGTH_COUNTER_BITS = 3;

    // caf_peak_select defaults: slices per frame and the counter that walks them
    localparam int CAF_PS_NUM_SLICES = 4;
    localparam int CAF_PS_SLICE_BITS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } caf_state_t;

endpackage

// File: rtl/caf_peak_select.sv
// Frame-level peak selector: folds one (out_max, index) result per frequency slice into
// a global peak and presents it, with a threshold-detect flag, until downstream accepts.
module caf_peak_select
    import caf_pkg::*;
#(
    parameter int out_max_bits        = CAF_OUT_MAX_BITS,
    parameter int length_counter_bits = CAF_LENGTH_COUNTER_BITS,
    parameter int num_slices          = CAF_PS_NUM_SLICES,
    parameter int slice_bits          = CAF_PS_SLICE_BITS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           m_axis_tvalid,
    input  logic [out_max_bits-1:0]        out_max,
    input  logic [length_counter_bits-1:0] index,
    output logic                           s_axis_tready,
    input  logic [out_max_bits-1:0]        threshold,
    input  logic                           m_axis_tready,
    output logic [out_max_bits-1:0]        peak_max,
    output logic [length_counter_bits-1:0] peak_index,
    output logic [slice_bits-1:0]          peak_slice,
    output logic                           detected,
    output logic                           s_axis_tvalid
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Our ready/valid are pure state decodes, so neither depends on the partner's signal.
    caf_state_t state_q;
    caf_state_t state_d;

    logic [slice_bits-1:0]          slice_cnt;
    logic [out_max_bits-1:0]        run_max;
    logic [length_counter_bits-1:0] run_index;
    logic [slice_bits-1:0]          run_slice;

    logic                           accept;
    logic                           last_slice;
    logic                           take;
    logic [out_max_bits-1:0]        nxt_max;
    logic [length_counter_bits-1:0] nxt_index;
    logic [slice_bits-1:0]          nxt_slice;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                s_axis_tready = 1'b1;
                if (accept && last_slice) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                s_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept     = m_axis_tvalid & s_axis_tready;
    assign last_slice = (slice_cnt == slice_bits'(num_slices - 1));

    // Strictly-greater replacement keeps the earliest slice on ties.
    assign take      = (slice_cnt == '0) || (out_max > run_max);
    assign nxt_max   = take ? out_max   : run_max;
    assign nxt_index = take ? index     : run_index;
    assign nxt_slice = take ? slice_cnt : run_slice;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_cnt  <= '0;
            run_max    <= '0;
            run_index  <= '0;
            run_slice  <= '0;
            peak_max   <= '0;
            peak_index <= '0;
            peak_slice <= '0;
            detected   <= 1'b0;
        end else if (accept) begin
            run_max   <= nxt_max;
            run_index <= nxt_index;
            run_slice <= nxt_slice;
            if (last_slice) begin
                slice_cnt  <= '0;
                peak_max   <= nxt_max;
                peak_index <= nxt_index;
                peak_slice <= nxt_slice;
                detected   <= (nxt_max >= threshold);
            end else begin
                slice_cnt <= slice_cnt + slice_bits'(1);
            end
        end
    end

endmodule

// File: tb/tb_caf_peak_select.sv
// Self-checking bench for caf_peak_select: frame-level argmax model plus directed frames.
module tb_caf_peak_select;

    localparam int OMB = 5;
    localparam int LCB = 3;
    localparam int NS  = 4;
    localparam int SB  = 2;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           m_axis_tvalid = 1'b0;
    logic [OMB-1:0] out_max = '0;
    logic [LCB-1:0] index = '0;
    logic [OMB-1:0] threshold = '0;
    logic           m_axis_tready = 1'b1;
    logic           s_axis_tready;
    logic [OMB-1:0] peak_max;
    logic [LCB-1:0] peak_index;
    logic [SB-1:0]  peak_slice;
    logic           detected;
    logic           s_axis_tvalid;

    always #5 clk = ~clk;

    caf_peak_select #(
        .out_max_bits(OMB),
        .length_counter_bits(LCB),
        .num_slices(NS),
        .slice_bits(SB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m_axis_tvalid(m_axis_tvalid),
        .out_max(out_max),
        .index(index),
        .s_axis_tready(s_axis_tready),
        .threshold(threshold),
        .m_axis_tready(m_axis_tready),
        .peak_max(peak_max),
        .peak_index(peak_index),
        .peak_slice(peak_slice),
        .detected(detected),
        .s_axis_tvalid(s_axis_tvalid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Phase 0 = the one post-reset cycle, 1 = collecting slices, 2 = result on offer.
    int m_phase = 0;
    int m_mag[$];
    int m_lag[$];
    int m_max = 0, m_idx = 0, m_slice = 0, m_det = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_mag.delete();
            m_lag.delete();
            m_max = 0; m_idx = 0; m_slice = 0; m_det = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: if (m_axis_tvalid) begin
                    m_mag.push_back(int'(out_max));
                    m_lag.push_back(int'(index));
                    if (m_mag.size() == NS) begin
                        int best;
                        best = 0;
                        for (int i = 1; i < NS; i++)
                            if (m_mag[i] > m_mag[best]) best = i;
                        m_max   = m_mag[best];
                        m_idx   = m_lag[best];
                        m_slice = best;
                        m_det   = int'(m_max >= int'(threshold));
                        m_mag.delete();
                        m_lag.delete();
                        m_phase = 2;
                    end
                end
                default: if (m_axis_tready) m_phase = 1;
            endcase
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        check("cmp_tready", int'(s_axis_tready), int'(m_phase == 1));
        check("cmp_tvalid", int'(s_axis_tvalid), int'(m_phase == 2));
        check("cmp_peak_max", int'(peak_max), m_max);
        check("cmp_peak_index", int'(peak_index), m_idx);
        check("cmp_peak_slice", int'(peak_slice), m_slice);
        check("cmp_detected", int'(detected), m_det);
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+2; returns at posedge+2 after the accepting edge with valid low.
    task automatic put(input int om, input int idx);
        bit done;
        done = 0;
        m_axis_tvalid = 1'b1;
        out_max = OMB'(om);
        index   = LCB'(idx);
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                @(posedge clk);
                #2;
                done = 1;
            end
        end
        m_axis_tvalid = 1'b0;
        if (!done) check("put_accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Result must be visible in the cycle right after the last accept.
    task automatic check_result(input string name, input int pm, input int pi,
                                input int ps, input int det);
        @(negedge clk);
        check({name, "_tvalid"}, int'(s_axis_tvalid), 1);
        check({name, "_peak_max"}, int'(peak_max), pm);
        check({name, "_peak_index"}, int'(peak_index), pi);
        check({name, "_peak_slice"}, int'(peak_slice), ps);
        check({name, "_detected"}, int'(detected), det);
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string name);
        check({name, "_tready"}, int'(s_axis_tready), 0);
        check({name, "_tvalid"}, int'(s_axis_tvalid), 0);
        check({name, "_peak_max"}, int'(peak_max), 0);
        check({name, "_peak_index"}, int'(peak_index), 0);
        check({name, "_peak_slice"}, int'(peak_slice), 0);
        check({name, "_detected"}, int'(detected), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cycle_tready", int'(s_axis_tready), 0);
        @(posedge clk);
        #2;

        // Basic frame
        threshold = 5'd10;
        put(3, 2); put(17, 5); put(9, 1); put(12, 6);
        check_result("basic", 17, 5, 1, 1);

        // Tie: 17 at slices 1 and 3, earliest wins
        threshold = 5'd20;
        put(1, 0); put(17, 5); put(4, 3); put(17, 6);
        check_result("tie", 17, 5, 1, 0);

        // All-zero frame with threshold 0
        threshold = 5'd0;
        put(0, 3); put(0, 1); put(0, 2); put(0, 7);
        check_result("zero", 0, 3, 0, 1);

        // Backpressure: result held 5 cycles, junk valid must be ignored
        threshold = 5'd8;
        m_axis_tready = 1'b0;
        put(8, 4); put(2, 1); put(7, 7); put(5, 0);
        m_axis_tvalid = 1'b1;
        out_max = 5'd31;
        index   = 3'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_tready", int'(s_axis_tready), 0);
            check("bp_tvalid", int'(s_axis_tvalid), 1);
            check("bp_peak_max", int'(peak_max), 8);
            check("bp_peak_index", int'(peak_index), 4);
            check("bp_peak_slice", int'(peak_slice), 0);
            check("bp_detected", int'(detected), 1);
            @(posedge clk);
            #2;
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("bp_release_tvalid", int'(s_axis_tvalid), 1);
        @(posedge clk);
        #2;

        // Sparse frame; its first slice lands the cycle after the handshake
        threshold = 5'd31;
        out_max = 5'd10;
        index   = 3'd1;
        @(negedge clk);
        check("ready_after_handshake", int'(s_axis_tready), 1);
        @(posedge clk);
        #2;
        m_axis_tvalid = 1'b0;
        idle(2);
        put(30, 2);
        idle(1);
        put(29, 3);
        put(30, 4);
        check_result("sparse", 30, 2, 1, 0);

        // Reset mid-frame after two accepts, then a clean frame
        threshold = 5'd5;
        put(31, 7); put(31, 7);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_idle_tready", int'(s_axis_tready), 0);
        @(posedge clk);
        #2;
        @(negedge clk);
        check("rst_accum_tready", int'(s_axis_tready), 1);
        @(posedge clk);
        #2;
        put(4, 1); put(2, 2); put(3, 3); put(6, 4);
        check_result("after_reset", 6, 4, 3, 1);

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/caf_peak_select.md
# caf_peak_select

Receiving end of the CAF slice output stream. Accepts one `(out_max, index)` result per frequency slice, in frequency order, for a frame of `num_slices` slices, and tracks the global peak across the frame. At frame end it presents the peak magnitude, its time-lag index, its slice (frequency) number and a threshold-detect flag. It drives the ready back into the slice chain and holds the result until the downstream consumer accepts it.

## Interface
- `out_max_bits`, 5: width of slice peak magnitude (unsigned).
- `length_counter_bits`, 3: width of slice time-lag index.
- `num_slices`, 4: slice results per frame; must be ≥ 2.
- `slice_bits`, 2: width of slice counter; must satisfy 2^slice_bits ≥ num_slices.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `m_axis_tvalid`  in  1  slice result valid (driven by the slice's output valid).
- `out_max`  in  out_max_bits  slice peak magnitude.
- `index`  in  length_counter_bits  slice peak lag.
- `s_axis_tready`  out  1  ready to accept a slice result (drives the slice's `m_axis_tready`).
- `threshold`  in  out_max_bits  detect threshold; sampled on the last-slice accept.
- `m_axis_tready`  in  1  downstream ready for the frame result.
- `peak_max`  out  out_max_bits  frame peak magnitude.
- `peak_index`  out  length_counter_bits  lag of frame peak.
- `peak_slice`  out  slice_bits  slice number of frame peak.
- `detected`  out  1  `peak_max >= threshold`.
- `s_axis_tvalid`  out  1  frame result valid.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE: entered on reset; advances to ACCUM unconditionally on the first clock edge after `rst_n` deasserts.
- ACCUM: `s_axis_tready`=1. An accept occurs when `m_axis_tvalid & s_axis_tready`.
  - On each accept, `slice_cnt` increments.
  - Slice 0 loads the running peak unconditionally.
  - Later slices replace the running peak only when `out_max` is strictly greater than the running max, so ties keep the earliest slice.
  - The accept with `slice_cnt == num_slices-1` does the following on the same edge:
    - updates the peak;
    - registers `peak_*` and `detected` (against that cycle's `threshold`, unsigned compare using the final peak);
    - resets `slice_cnt` to 0;
    - moves to HOLD.
- HOLD: `s_axis_tvalid`=1, `s_axis_tready`=0.
  - Outputs stay stable until `m_axis_tready`=1.
  - On the handshake edge, return to ACCUM.
- The running peak is internal. `peak_*` and `detected` change only on the frame-end edge.
- Reset at any point, including mid-frame or in HOLD:
  - the partial frame is discarded;
  - `slice_cnt` is cleared;
  - all outputs return to their reset values immediately (asynchronous).

## Timing
- Reset values: `s_axis_tready`=0, `s_axis_tvalid`=0, `peak_max`=0, `peak_index`=0, `peak_slice`=0, `detected`=0.
- `s_axis_tready` and `s_axis_tvalid` are registered (decoded from the state register, no combinational path from inputs).
- The first `s_axis_tready`=1 is in the second cycle after reset release.
- Frame result latency: `s_axis_tvalid` rises the cycle after the last-slice accept.
- Maximum throughput is one slice result per cycle. Minimum frame period is num_slices + 1 cycles with `m_axis_tready` held high.
- After the result handshake, `s_axis_tready` is 1 in the next cycle. There is no accept during the handshake cycle itself.
- `m_axis_tvalid` gaps in ACCUM stall counting; no timeout.
- `m_axis_tready` is ignored outside HOLD. `m_axis_tvalid` is ignored outside ACCUM.

## Structure
- Shared package `caf_pkg`: state encoding constants IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2. Add `caf_peak_select` default width constants alongside the existing CAF width defaults.
- Single module, no sub-module. The compare/update logic is small enough to stay inline.

## Test plan
- Basic frame (num_slices=4, threshold=10, `m_axis_tready`=1):
  - stimulus: back-to-back (out_max, index) = (3,2), (17,5), (9,1), (12,6);
  - required: `s_axis_tvalid` one cycle after the 4th accept, with `peak_max`=17, `peak_index`=5, `peak_slice`=1, `detected`=1.
- Tie rule:
  - stimulus: (17,5), (17,6) placed at slices 1 and 3;
  - required: `peak_slice`=1, `peak_index`=5.
  - stimulus: all-zero frame with threshold=0;
  - required: `peak_max`=0, `peak_slice`=0, `detected`=1.
- Backpressure:
  - stimulus: hold `m_axis_tready`=0 for 5 cycles in HOLD;
  - required: outputs stable, `s_axis_tready`=0, and new `m_axis_tvalid` ignored;
  - then on release: handshake completes, and the next frame's first accept occurs one cycle later.
- Sparse input:
  - stimulus: `m_axis_tvalid` toggling 1,0,0,1,0,1,1 across one frame with threshold=31 and max 30;
  - required: exactly 4 accepts counted, result correct, `detected`=0.
- Reset mid-frame:
  - stimulus: pull `rst_n` low after 2 accepts, release, then send a full new frame;
  - required: all outputs go to 0 immediately on reset, IDLE lasts one cycle, and the result reflects only the new frame.
